// File: rtl/dmix_spdif_rx_top.sv
// S/PDIF biphase-mark receiver: oversampled edge timing -> preamble/slot decode -> one strobe per subframe.
// valid_o fires 3 clk after the preamble edge that completes the P slot; no backpressure, the strobe is not held.
module dmix_spdif_rx_top #(
  parameter int CLKS_PER_UI = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spdif_i,
  output logic [23:0] data_o,
  output logic        ch_o,
  output logic        blk_o,
  output logic        v_o,
  output logic        u_o,
  output logic        c_o,
  output logic        parity_err_o,
  output logic        valid_o,
  output logic        lock_o
);

  typedef enum logic [1:0] {HUNT, PRE, DATA} state_t;

  localparam logic [1:0] C_ERR = 2'd0;
  localparam logic [1:0] C_1   = 2'd1;
  localparam logic [1:0] C_2   = 2'd2;
  localparam logic [1:0] C_3   = 2'd3;

  // Thresholds are compared against 2*width so that the half-UI boundaries stay integral.
  localparam logic [9:0] LIM_1  = 10'(3 * CLKS_PER_UI);
  localparam logic [9:0] LIM_2  = 10'(5 * CLKS_PER_UI);
  localparam logic [9:0] LIM_3  = 10'(7 * CLKS_PER_UI);
  localparam logic [8:0] LIM_TO = 9'(4 * CLKS_PER_UI);

  state_t      state, next_state;
  logic        sync1, sync2, sync3;
  logic        edge_det;
  logic [7:0]  cnt;
  logic [8:0]  width;
  logic [9:0]  width2;
  logic [1:0]  pc;
  logic        timeout;

  logic [1:0]  pre_idx;
  logic [1:0]  p1, p2;
  logic        half;
  logic [4:0]  bit_cnt;
  logic [27:0] sr;
  logic [27:0] sr_next;
  logic        cur_ch, cur_blk;

  logic        err, goto_pre1, enter_data, new_ch, new_blk;
  logic        bit_vld, bit_val, set_half, done;

  assign edge_det = sync2 ^ sync3;
  assign width    = {1'b0, cnt} + 9'd1;
  assign width2   = {width, 1'b0};
  assign timeout  = !edge_det && (width >= LIM_TO);
  assign sr_next  = {bit_val, sr[27:1]};

  always_comb begin
    pc = C_ERR;
    if (width2 < LIM_1)      pc = C_1;
    else if (width2 < LIM_2) pc = C_2;
    else if (width2 < LIM_3) pc = C_3;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HUNT;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    err        = 1'b0;
    goto_pre1  = 1'b0;
    enter_data = 1'b0;
    new_ch     = 1'b0;
    new_blk    = 1'b0;
    bit_vld    = 1'b0;
    bit_val    = 1'b0;
    set_half   = 1'b0;
    done       = 1'b0;
    if (timeout) begin
      err        = 1'b1;
      next_state = HUNT;
    end else if (edge_det) begin
      case (state)
        HUNT: begin
          if (pc == C_3) begin
            next_state = PRE;
            goto_pre1  = 1'b1;
          end
        end
        PRE: begin
          if (pc == C_ERR || (pre_idx == 2'd0 && pc != C_3)) begin
            err        = 1'b1;
            next_state = HUNT;
          end else if (pre_idx == 2'd3) begin
            case ({p1, p2, pc})
              {C_1, C_1, C_3}: begin enter_data = 1'b1; new_blk = 1'b1; end
              {C_3, C_1, C_1}: enter_data = 1'b1;
              {C_2, C_1, C_2}: begin enter_data = 1'b1; new_ch = 1'b1; end
              default:         err = 1'b1;
            endcase
            next_state = enter_data ? DATA : HUNT;
          end
        end
        DATA: begin
          if (pc == C_3) begin
            // A long pulse here is most likely the next preamble arriving early: resync on it.
            err        = 1'b1;
            goto_pre1  = 1'b1;
            next_state = PRE;
          end else if (pc == C_ERR || (half && pc != C_1)) begin
            err        = 1'b1;
            next_state = HUNT;
          end else if (half) begin
            bit_vld = 1'b1;
            bit_val = 1'b1;
          end else if (pc == C_2) begin
            bit_vld = 1'b1;
          end else begin
            set_half = 1'b1;
          end
          if (bit_vld && bit_cnt == 5'd27) begin
            done       = 1'b1;
            next_state = PRE;
          end
        end
        default: next_state = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync3        <= 1'b0;
      cnt          <= 8'd0;
      pre_idx      <= 2'd0;
      p1           <= C_ERR;
      p2           <= C_ERR;
      half         <= 1'b0;
      bit_cnt      <= 5'd0;
      sr           <= 28'd0;
      cur_ch       <= 1'b0;
      cur_blk      <= 1'b0;
      data_o       <= 24'd0;
      ch_o         <= 1'b0;
      blk_o        <= 1'b0;
      v_o          <= 1'b0;
      u_o          <= 1'b0;
      c_o          <= 1'b0;
      parity_err_o <= 1'b0;
      valid_o      <= 1'b0;
      lock_o       <= 1'b0;
    end else begin
      sync1 <= spdif_i;
      sync2 <= sync1;
      sync3 <= sync2;

      if (edge_det)          cnt <= 8'd0;
      else if (cnt != 8'hFF) cnt <= cnt + 8'd1;

      if (goto_pre1) begin
        pre_idx <= 2'd1;
      end else if (done) begin
        pre_idx <= 2'd0;
      end else if (state == PRE && edge_det && !err) begin
        pre_idx <= pre_idx + 2'd1;
        if (pre_idx == 2'd1) p1 <= pc;
        if (pre_idx == 2'd2) p2 <= pc;
      end

      if (enter_data) begin
        cur_ch  <= new_ch;
        cur_blk <= new_blk;
        bit_cnt <= 5'd0;
        half    <= 1'b0;
      end else if (bit_vld) begin
        sr      <= sr_next;
        bit_cnt <= bit_cnt + 5'd1;
        half    <= 1'b0;
      end else if (set_half) begin
        half <= 1'b1;
      end

      valid_o <= done;
      if (done) begin
        data_o       <= sr_next[23:0];
        v_o          <= sr_next[24];
        u_o          <= sr_next[25];
        c_o          <= sr_next[26];
        parity_err_o <= ^sr_next;
        ch_o         <= cur_ch;
        blk_o        <= cur_blk;
      end

      if (err)       lock_o <= 1'b0;
      else if (done) lock_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmix_spdif_rx_top.sv
// Directed bench for dmix_spdif_rx_top: builds BMC line streams and scoreboards every decoded subframe.
`timescale 1ns/1ps
module tb_dmix_spdif_rx_top;

  typedef struct packed {
    logic [23:0] data;
    logic        ch;
    logic        blk;
    logic        v;
    logic        u;
    logic        c;
    logic        perr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        line = 1'b0;
  logic [23:0] data_o;
  logic        ch_o, blk_o, v_o, u_o, c_o, parity_err_o, valid_o, lock_o;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;
  real  ui_ns = 40.0;
  real  pre_edge_t = 0.0;
  real  dt;
  real  t0;
  logic prev_valid = 1'b0;

  dmix_spdif_rx_top #(.CLKS_PER_UI(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .spdif_i      (line),
    .data_o       (data_o),
    .ch_o         (ch_o),
    .blk_o        (blk_o),
    .v_o          (v_o),
    .u_o          (u_o),
    .c_o          (c_o),
    .parity_err_o (parity_err_o),
    .valid_o      (valid_o),
    .lock_o       (lock_o)
  );

  always #2.5 clk = ~clk;

  function automatic logic [31:0] outs();
    return {data_o, ch_o, blk_o, v_o, u_o, c_o, parity_err_o, valid_o, lock_o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic pulse(input int n);
    line = ~line;
    #(n * ui_ns);
  endtask

  // pre: 0 = B, 1 = M, 2 = W
  task automatic send_sub(input int pre, input logic [23:0] d, input logic v, input logic u,
                          input logic c, input logic p, input int nbits, input bit push);
    logic [27:0] bits;
    exp_t e;
    bits = {p, c, u, v, d};
    pre_edge_t = $realtime;
    pulse(3);
    case (pre)
      0:       begin pulse(1); pulse(1); pulse(3); end
      1:       begin pulse(3); pulse(1); pulse(1); end
      default: begin pulse(2); pulse(1); pulse(2); end
    endcase
    for (int i = 0; i < nbits; i++) begin
      if (bits[i]) begin pulse(1); pulse(1); end
      else pulse(2);
    end
    if (push) begin
      e.data = d; e.ch = (pre == 2); e.blk = (pre == 0);
      e.v = v; e.u = u; e.c = c; e.perr = ^bits;
      q.push_back(e);
    end
  endtask

  task automatic trailing_edge();
    pre_edge_t = $realtime;
    line = ~line;
    #(8 * ui_ns);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (valid_o) begin
      dt = $realtime - pre_edge_t;
      chk("strobe_width", {63'd0, prev_valid}, 64'd0);
      chk("strobe_latency", {63'd0, (dt > 10.9 && dt < 16.1)}, 64'd1);
      chk("strobe_expected", {63'd0, (q.size() > 0)}, 64'd1);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("sample", {33'd0, data_o, ch_o, blk_o, v_o, u_o, c_o, parity_err_o, lock_o},
            {33'd0, mon_e, 1'b1});
      end
    end
    prev_valid = valid_o;
  end

  initial begin
    logic [23:0] d;
    // reset held with a busy line
    rst = 1'b0;
    repeat (20) #7 line = ~line;
    chk("reset_outs", {32'd0, outs()}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_lock", {63'd0, lock_o}, 64'd0);

    // basic stream and parity
    @(posedge clk); #1;
    send_sub(0, 24'h000000, 1, 1, 1, 1, 28, 1);
    send_sub(2, 24'h000001, 1, 1, 1, 1, 28, 1);
    send_sub(1, 24'h000003, 1, 1, 1, 1, 28, 1);
    send_sub(2, 24'h000002, 1, 1, 1, 1, 28, 1);
    trailing_edge();
    chk("basic_drained", 64'(q.size()), 64'd0);
    chk("basic_timeout_unlock", {63'd0, lock_o}, 64'd0);

    // counter payload, B every 64 frames
    @(posedge clk); #1;
    for (int i = 0; i < 130; i++) begin
      d = 24'(i);
      send_sub((i % 2 == 1) ? 2 : ((i % 128 == 0) ? 0 : 1), d, d[1], d[2], d[3],
               ^{d, d[1], d[2], d[3]}, 28, 1);
    end
    trailing_edge();
    chk("stream_drained", 64'(q.size()), 64'd0);

    // line goes static mid-subframe
    @(posedge clk); #1;
    send_sub(0, 24'h5A5A5A, 0, 1, 0, 1, 28, 1);
    send_sub(1, 24'h123456, 0, 0, 0, 0, 10, 0);
    line = ~line;
    #160;
    chk("lock_before_timeout", {63'd0, lock_o}, 64'd1);
    #25;
    chk("lock_after_timeout", {63'd0, lock_o}, 64'd0);
    #15;
    send_sub(1, 24'hC0FFEE, 1, 0, 1, 0, 28, 1);
    send_sub(2, 24'h00F00D, 0, 1, 1, 1, 28, 1);
    trailing_edge();
    chk("timeout_drained", 64'(q.size()), 64'd0);

    // stretched UI; last subframe has no trailing edge and must be dropped
    ui_ns = 44.0;
    @(posedge clk); #1.5;
    for (int i = 0; i < 6; i++) begin
      d = 24'($urandom);
      send_sub((i == 0) ? 0 : ((i % 2 == 1) ? 2 : 1), d, d[5], d[9], d[13], d[0], 28, (i != 5));
    end
    #(8 * ui_ns);
    chk("stretch_drained", 64'(q.size()), 64'd0);
    chk("stretch_last_dropped", {63'd0, lock_o}, 64'd0);
    ui_ns = 40.0;

    // reset asserted mid-subframe
    @(posedge clk); #1;
    send_sub(0, 24'hABCDEF, 1, 1, 0, 0, 28, 1);
    send_sub(2, 24'h777777, 0, 0, 0, 0, 12, 0);
    rst = 1'b0;
    #1;
    chk("midreset_outs", {32'd0, outs()}, 64'd0);
    #(ui_ns - 1.0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) pulse(2);
    send_sub(1, 24'h800001, 0, 1, 0, 1, 28, 1);
    send_sub(2, 24'h7FFFFE, 1, 0, 1, 0, 28, 1);
    trailing_edge();
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
